wptr_full_level: RTL and testbench

Write-side pointer and flag controller for an asynchronous FIFO, and the parametrised successor to the basic gray-pointer/full block. It keeps the binary and gray write pointers and converts the synchronised gray read pointer to binary. From those it derives a registered full flag, a programmable almost-full flag and a registered free-slot count. It sits in the write clock domain between the producer, the dual-port RAM write port and the read-pointer synchroniser.

---
 rtl/wptr_full_level.sv | 117 +++++++++++
 tb/tb_wptr_full_level.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wptr_full_level.sv
// Write-side pointer, full/almost-full flag and free-count controller for an async FIFO.
// Optional overflow status (wovf, wovf_cnt, wovf_clr) is enabled by defining WPTR_FULL_OVF_EN.
module wptr_full_level #(
    parameter int ADDRSIZE = 8,
    parameter int AF_RESET = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                waf_load,
    input  logic [ADDRSIZE:0]   waf_level,
`ifdef WPTR_FULL_OVF_EN
    input  logic                wovf_clr,
    output logic                wovf,
    output logic [7:0]          wovf_cnt,
`endif
    output logic                wen,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wfree
);

    localparam int PW    = ADDRSIZE + 1;
    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_V    = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [ADDRSIZE:0] AF_RESET_V = (AF_RESET >= DEPTH) ? DEPTH_V : PW'(AF_RESET);
    localparam logic              AF_FLAG_RESET = (DEPTH <= AF_RESET);

    logic [ADDRSIZE:0] wbin_reg;
    logic [ADDRSIZE:0] wptr_reg;
    logic              wfull_reg;
    logic              walmost_full_reg;
    logic [ADDRSIZE:0] wfree_reg;
    logic [ADDRSIZE:0] af_level_reg;

    logic [ADDRSIZE:0] wbin_next;
    logic [ADDRSIZE:0] wgray_next;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] used_next;
    logic [ADDRSIZE:0] free_next;
    logic [ADDRSIZE:0] af_level_next;

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_g2b
            assign rbin_s[gi] = ^wq2_rptr[ADDRSIZE:gi];
        end
    endgenerate

    assign wen        = winc & ~wfull_reg;
    assign waddr      = wbin_reg[ADDRSIZE-1:0];
    assign wbin_next  = wbin_reg + PW'(wen);
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    assign used_next  = wbin_next - rbin_s;
    assign free_next  = DEPTH_V - used_next;
    assign af_level_next = (waf_level > DEPTH_V) ? DEPTH_V : waf_level;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_reg         <= '0;
            wptr_reg         <= '0;
            wfull_reg        <= 1'b0;
            walmost_full_reg <= AF_FLAG_RESET;
            wfree_reg        <= DEPTH_V;
            af_level_reg     <= AF_RESET_V;
        end else begin
            wbin_reg         <= wbin_next;
            wptr_reg         <= wgray_next;
            wfull_reg        <= (used_next == DEPTH_V);
            wfree_reg        <= free_next;
            // A level loaded on this edge only takes effect from the next one.
            walmost_full_reg <= (free_next <= af_level_reg);
            if (waf_load) begin
                af_level_reg <= af_level_next;
            end
        end
    end

    assign wptr         = wptr_reg;
    assign wfull        = wfull_reg;
    assign walmost_full = walmost_full_reg;
    assign wfree        = wfree_reg;

`ifdef WPTR_FULL_OVF_EN
    logic       wovf_reg;
    logic [7:0] wovf_cnt_reg;
    logic       ovf_event;

    assign ovf_event = winc & wfull_reg;

    // A fresh overflow wins over a clear on the same edge.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wovf_reg     <= 1'b0;
            wovf_cnt_reg <= '0;
        end else if (ovf_event) begin
            wovf_reg <= 1'b1;
            if (wovf_clr) begin
                wovf_cnt_reg <= 8'd1;
            end else if (wovf_cnt_reg != 8'hFF) begin
                wovf_cnt_reg <= wovf_cnt_reg + 8'd1;
            end
        end else if (wovf_clr) begin
            wovf_reg     <= 1'b0;
            wovf_cnt_reg <= '0;
        end
    end

    assign wovf     = wovf_reg;
    assign wovf_cnt = wovf_cnt_reg;
`endif

endmodule

// File: tb/tb_wptr_full_level.sv
// Directed, table-driven bench for wptr_full_level at ADDRSIZE=3 (DEPTH=8), AF_RESET=2.
// Define WPTR_FULL_OVF_EN to also exercise the overflow status outputs.
module tb_wptr_full_level;

    logic       wclk;
    logic       wrst;
    logic       winc;
    logic [3:0] wq2_rptr;
    logic       waf_load;
    logic [3:0] waf_level;
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [3:0] wfree;
`ifdef WPTR_FULL_OVF_EN
    logic       wovf_clr;
    logic       wovf;
    logic [7:0] wovf_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    wptr_full_level #(.ADDRSIZE(3), .AF_RESET(2)) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .winc        (winc),
        .wq2_rptr    (wq2_rptr),
        .waf_load    (waf_load),
        .waf_level   (waf_level),
`ifdef WPTR_FULL_OVF_EN
        .wovf_clr    (wovf_clr),
        .wovf        (wovf),
        .wovf_cnt    (wovf_cnt),
`endif
        .wen         (wen),
        .waddr       (waddr),
        .wptr        (wptr),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wfree       (wfree)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic       winc;
        logic [3:0] rptr;
        logic       ld;
        logic [3:0] lvl;
        logic       clr;
        logic       e_wen;
        logic [2:0] e_waddr;
        logic [3:0] e_wptr;
        logic       e_full;
        logic       e_af;
        logic [3:0] e_free;
        logic       e_ovf;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s #%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic wi, input logic [3:0] rp, input logic ld, input logic [3:0] lvl,
                       input logic clr, input logic ew, input logic [2:0] ea, input logic [3:0] ep,
                       input logic ef, input logic eaf, input logic [3:0] efr,
                       input logic eo, input logic [7:0] ec);
        vec_t v;
        v = '{wi, rp, ld, lvl, clr, ew, ea, ep, ef, eaf, efr, eo, ec};
        vecs.push_back(v);
    endtask

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        logic [3:0] mb;

        // Fill from empty: waddr 0..7, almost-full after 6th write, full after 8th
        add(1, 4'h0, 0, 0, 0,  1, 3'd0, 4'b0001, 0, 0, 4'd7, 0, 8'd0);
        add(1, 4'h0, 0, 0, 0,  1, 3'd1, 4'b0011, 0, 0, 4'd6, 0, 8'd0);
        add(1, 4'h0, 0, 0, 0,  1, 3'd2, 4'b0010, 0, 0, 4'd5, 0, 8'd0);
        add(1, 4'h0, 0, 0, 0,  1, 3'd3, 4'b0110, 0, 0, 4'd4, 0, 8'd0);
        add(1, 4'h0, 0, 0, 0,  1, 3'd4, 4'b0111, 0, 0, 4'd3, 0, 8'd0);
        add(1, 4'h0, 0, 0, 0,  1, 3'd5, 4'b0101, 0, 1, 4'd2, 0, 8'd0);
        add(1, 4'h0, 0, 0, 0,  1, 3'd6, 4'b0100, 0, 1, 4'd1, 0, 8'd0);
        add(1, 4'h0, 0, 0, 0,  1, 3'd7, 4'b1100, 1, 1, 4'd0, 0, 8'd0);
        // Writes while full are dropped
        add(1, 4'h0, 0, 0, 0,  0, 3'd0, 4'b1100, 1, 1, 4'd0, 1, 8'd1);
        add(1, 4'h0, 0, 0, 0,  0, 3'd0, 4'b1100, 1, 1, 4'd0, 1, 8'd2);
        add(1, 4'h0, 0, 0, 0,  0, 3'd0, 4'b1100, 1, 1, 4'd0, 1, 8'd3);
        // Reader reaches binary 3; overflow status cleared on the same edge
        add(0, 4'b0010, 0, 0, 1, 0, 3'd0, 4'b1100, 0, 0, 4'd3, 0, 8'd0);
        add(1, 4'b0010, 0, 0, 0, 1, 3'd0, 4'b1101, 0, 1, 4'd2, 0, 8'd0);
        add(1, 4'b0010, 0, 0, 0, 1, 3'd1, 4'b1111, 0, 1, 4'd1, 0, 8'd0);
        // Simultaneous write and read advance (rbin 3 -> 4) keeps wfree at 1
        add(1, 4'b0110, 0, 0, 0, 1, 3'd2, 4'b1110, 0, 1, 4'd1, 0, 8'd0);
        // Level loads take effect one edge later
        add(0, 4'b0110, 1, 4'd0, 0, 0, 3'd3, 4'b1110, 0, 1, 4'd1, 0, 8'd0);
        add(0, 4'b0110, 0, 4'd0, 0, 0, 3'd3, 4'b1110, 0, 0, 4'd1, 0, 8'd0);
        add(0, 4'b0110, 1, 4'd1, 0, 0, 3'd3, 4'b1110, 0, 0, 4'd1, 0, 8'd0);
        add(0, 4'b0110, 0, 4'd0, 0, 0, 3'd3, 4'b1110, 0, 1, 4'd1, 0, 8'd0);
        // Empty FIFO with level = DEPTH: free 8 <= 8
        add(0, 4'b1110, 1, 4'd8, 0, 0, 3'd3, 4'b1110, 0, 0, 4'd8, 0, 8'd0);
        add(0, 4'b1110, 0, 4'd0, 0, 0, 3'd3, 4'b1110, 0, 1, 4'd8, 0, 8'd0);

        wrst = 1'b1; winc = 1'b0; wq2_rptr = '0; waf_load = 1'b0; waf_level = '0;
`ifdef WPTR_FULL_OVF_EN
        wovf_clr = 1'b0;
`endif
        #1;
        chk("rst_wptr", 0, 32'(wptr), 32'h0);
        chk("rst_waddr", 0, 32'(waddr), 32'h0);
        chk("rst_wfull", 0, 32'(wfull), 32'h0);
        chk("rst_af", 0, 32'(walmost_full), 32'h0);
        chk("rst_wfree", 0, 32'(wfree), 32'd8);
        #11 wrst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge wclk);
            winc = vecs[i].winc; wq2_rptr = vecs[i].rptr;
            waf_load = vecs[i].ld; waf_level = vecs[i].lvl;
`ifdef WPTR_FULL_OVF_EN
            wovf_clr = vecs[i].clr;
`endif
            #1;
            chk("wen", i, 32'(wen), 32'(vecs[i].e_wen));
            chk("waddr", i, 32'(waddr), 32'(vecs[i].e_waddr));
            @(posedge wclk);
            #1;
            chk("wptr", i, 32'(wptr), 32'(vecs[i].e_wptr));
            chk("wfull", i, 32'(wfull), 32'(vecs[i].e_full));
            chk("walmost_full", i, 32'(walmost_full), 32'(vecs[i].e_af));
            chk("wfree", i, 32'(wfree), 32'(vecs[i].e_free));
`ifdef WPTR_FULL_OVF_EN
            chk("wovf", i, 32'(wovf), 32'(vecs[i].e_ovf));
            chk("wovf_cnt", i, 32'(wovf_cnt), 32'(vecs[i].e_cnt));
`endif
            $display("[TB] vec %0d winc=%0b rptr=%b -> wptr=%b wfull=%0b waf=%0b wfree=%0d",
                     i, vecs[i].winc, vecs[i].rptr, wptr, wfull, walmost_full, wfree);
        end
        waf_load = 1'b0;
`ifdef WPTR_FULL_OVF_EN
        wovf_clr = 1'b0;
`endif

        // Mid-stream reset between clock edges must clear state immediately
        @(negedge wclk);
        #2 wrst = 1'b1; winc = 1'b1;
        #1;
        chk("mrst_wptr", 0, 32'(wptr), 32'h0);
        chk("mrst_waddr", 0, 32'(waddr), 32'h0);
        chk("mrst_wfull", 0, 32'(wfull), 32'h0);
        chk("mrst_af", 0, 32'(walmost_full), 32'h0);
        chk("mrst_wfree", 0, 32'(wfree), 32'd8);
        $display("[TB] mid-stream reset -> wptr=%b wfree=%0d", wptr, wfree);
        winc = 1'b0; wq2_rptr = '0;
        @(negedge wclk);
        wrst = 1'b0;

        // Wrap: reader tracks two entries behind, so wfree stays 6 through the 15->0 wrap
        mb = 4'd0;
        for (int i = 0; i < 22; i++) begin
            @(negedge wclk);
            winc = 1'b1;
            wq2_rptr = (i < 2) ? 4'h0 : gray(mb - 4'd1);
            #1;
            chk("wrap_waddr", i, 32'(waddr), 32'(mb[2:0]));
            @(posedge wclk);
            #1;
            mb = mb + 4'd1;
            chk("wrap_wptr", i, 32'(wptr), 32'(gray(mb)));
            chk("wrap_wfull", i, 32'(wfull), 32'h0);
            if (i >= 1) begin
                chk("wrap_wfree", i, 32'(wfree), 32'd6);
            end
            $display("[TB] wrap %0d wptr=%b wfree=%0d wfull=%0b", i, wptr, wfree, wfull);
        end
        winc = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
